// File: rtl/calc_pkg.sv
// Shared key codes, operator encodings, FSM state types and
// the keypad column/row decode used by the calculator front-end.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_DIV = 4'hD;
    localparam logic [3:0] KEY_EQ  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        PENDING = 2'b10,
        DONE    = 2'b11
    } entry_state_e;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } deb_state_e;

    // row 11 is the top row of the pad
    function automatic logic [3:0] decode_key(
        input logic [1:0] col,
        input logic [1:0] row
    );
        logic [3:0] k;
        case ({col, row})
            4'b00_11: k = 4'h1;
            4'b00_10: k = 4'h4;
            4'b00_01: k = 4'h7;
            4'b00_00: k = KEY_CLR;
            4'b01_11: k = 4'h2;
            4'b01_10: k = 4'h5;
            4'b01_01: k = 4'h8;
            4'b01_00: k = 4'h0;
            4'b10_11: k = 4'h3;
            4'b10_10: k = 4'h6;
            4'b10_01: k = 4'h9;
            4'b10_00: k = KEY_EQ;
            4'b11_11: k = KEY_ADD;
            4'b11_10: k = KEY_SUB;
            4'b11_01: k = KEY_MUL;
            default:  k = KEY_DIV;
        endcase
        return k;
    endfunction

    function automatic op_e key_to_op(input logic [3:0] k);
        return op_e'(k[1:0] + 2'b10);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad column scanner: one scan result per four cycles, then a
// press/release debounce that emits a single event per press.
module key_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       row_hit,
    input  logic [1:0] row_code,
    output logic [1:0] col_selector,
    output logic       key_valid,
    output logic [3:0] key,
    output logic       keytype
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    logic [1:0]    col_q;
    logic          seen_q;
    logic          ghost_q;
    logic [3:0]    code_q;
    deb_state_e    state_q;
    logic [3:0]    cand_q;
    logic [CW-1:0] match_q;
    logic [CW-1:0] rel_q;
    logic          valid_q;
    logic [3:0]    key_q;
    logic          type_q;

    logic          scan_end;
    logic          seen_prev;
    logic          ghost_prev;
    logic          scan_seen;
    logic          scan_ghost;
    logic          scan_empty;
    logic [3:0]    scan_code;
    logic [CW-1:0] match_nxt;
    logic [CW-1:0] rel_nxt;

    // accumulators restart at column 0 so a scan never sees stale hits
    always_comb begin
        seen_prev  = seen_q & (col_q != 2'd0);
        ghost_prev = ghost_q & (col_q != 2'd0);
        scan_seen  = seen_prev | row_hit;
        scan_ghost = ghost_prev | (seen_prev & row_hit);
        scan_empty = ~scan_seen;
        scan_code  = row_hit ? decode_key(col_q, row_code) : code_q;
        scan_end   = (col_q == 2'd3);
        match_nxt  = CW'(1);
        if (scan_code == cand_q && match_q != '0)
            match_nxt = match_q + 1'b1;
        rel_nxt    = rel_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q   <= 2'd0;
            seen_q  <= 1'b0;
            ghost_q <= 1'b0;
            code_q  <= 4'd0;
            state_q <= RELEASED;
            cand_q  <= 4'd0;
            match_q <= '0;
            rel_q   <= '0;
            valid_q <= 1'b0;
            key_q   <= 4'd0;
            type_q  <= 1'b1;
        end else begin
            col_q   <= col_q + 2'd1;
            seen_q  <= scan_seen;
            ghost_q <= scan_ghost;
            code_q  <= scan_code;
            valid_q <= 1'b0;
            if (scan_end) begin
                if (scan_ghost) begin
                    match_q <= '0;
                    rel_q   <= '0;
                end else begin
                    unique case (state_q)
                        RELEASED: begin
                            if (scan_empty) begin
                                match_q <= '0;
                            end else if (match_nxt == CNT_MAX) begin
                                valid_q <= 1'b1;
                                key_q   <= scan_code;
                                type_q  <= (scan_code <= 4'd9);
                                state_q <= PRESSED;
                                match_q <= '0;
                                rel_q   <= '0;
                            end else begin
                                cand_q  <= scan_code;
                                match_q <= match_nxt;
                            end
                        end
                        PRESSED: begin
                            if (!scan_empty) begin
                                rel_q <= '0;
                            end else if (rel_nxt == CNT_MAX) begin
                                state_q <= RELEASED;
                                rel_q   <= '0;
                                match_q <= '0;
                            end else begin
                                rel_q <= rel_nxt;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign col_selector = col_q;
    assign key_valid    = valid_q;
    assign key          = key_q;
    assign keytype      = type_q;

endmodule

// File: rtl/calc_input_ctrl.sv
// Calculator front-end: debounced keypad feeding the operand-entry
// FSM that hands a complete operation to the arithmetic unit.
module calc_input_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4,
    parameter int DIGITS         = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  row_hit,
    input  logic [1:0]            row_code,
    output logic [1:0]            col_selector,
    output logic                  key_valid,
    output logic [3:0]            key,
    output logic                  keytype,
    output logic [4*DIGITS-1:0]   operand_a,
    output logic [4*DIGITS-1:0]   operand_b,
    output logic [1:0]            op,
    output logic                  calc_start,
    input  logic                  calc_ready,
    output logic [1:0]            entry_state
);

    localparam int W  = 4 * DIGITS;
    localparam int NW = $clog2(DIGITS + 1);
    localparam logic [NW-1:0] DMAX = NW'(DIGITS);

    key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
        .clock       (clock),
        .reset       (reset),
        .row_hit     (row_hit),
        .row_code    (row_code),
        .col_selector(col_selector),
        .key_valid   (key_valid),
        .key         (key),
        .keytype     (keytype)
    );

    entry_state_e  state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [NW-1:0] na_q;
    logic [NW-1:0] nb_q;
    op_e           op_q;
    logic          start_q;

    logic          is_op;
    logic [W-1:0]  a_shift;
    logic [W-1:0]  b_shift;

    always_comb begin
        is_op   = (key >= KEY_ADD) && (key <= KEY_DIV);
        a_shift = (a_q << 4) | W'(key);
        b_shift = (b_q << 4) | W'(key);
    end

    always_ff @(posedge clock) begin
        if (reset || (key_valid && key == KEY_CLR)) begin
            state_q <= ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            na_q    <= '0;
            nb_q    <= '0;
            op_q    <= OP_ADD;
            start_q <= 1'b0;
        end else begin
            unique case (state_q)
                ENTER_A: if (key_valid) begin
                    if (keytype && na_q != DMAX) begin
                        a_q  <= a_shift;
                        na_q <= na_q + 1'b1;
                    end else if (is_op) begin
                        op_q    <= key_to_op(key);
                        state_q <= ENTER_B;
                    end
                end
                ENTER_B: if (key_valid) begin
                    if (keytype && nb_q != DMAX) begin
                        b_q  <= b_shift;
                        nb_q <= nb_q + 1'b1;
                    end else if (is_op && nb_q == '0) begin
                        op_q <= key_to_op(key);
                    end else if (key == KEY_EQ) begin
                        state_q <= PENDING;
                        start_q <= 1'b1;
                    end
                end
                PENDING: if (start_q && calc_ready) begin
                    state_q <= DONE;
                    start_q <= 1'b0;
                end
                DONE: if (key_valid && keytype) begin
                    a_q     <= W'(key);
                    b_q     <= '0;
                    na_q    <= NW'(1);
                    nb_q    <= '0;
                    state_q <= ENTER_A;
                end
            endcase
        end
    end

    assign operand_a   = a_q;
    assign operand_b   = b_q;
    assign op          = op_q;
    assign calc_start  = start_q;
    assign entry_state = state_q;

endmodule
